char_stream_feeder: RTL and testbench
=====================================

CHAR_STREAM_FEEDER -- requirements
Module: char_stream_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, >=4).
REQ-002 The block SHALL have parameter POS_W, default 20, width of the string position counter.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port in_char, input, 8, host byte.
REQ-006 The block SHALL have port in_valid, input, 1, host byte valid.
REQ-007 The block SHALL have port in_last, input, 1, marks the final byte of a string; qualified by in_valid.
REQ-008 The block SHALL have port in_ready, output, 1, block can accept a byte.
REQ-009 The block SHALL have port input_char_flag, input, 1, one-cycle consume request from the CSR traversal stage.
REQ-010 The block SHALL have port input_char, output, 8, FIFO head byte.
REQ-011 The block SHALL have port input_char_2, output, 8, byte after the head (lookahead).
REQ-012 The block SHALL have port char_valid, output, 1, input_char is valid.
REQ-013 The block SHALL have port char2_valid, output, 1, input_char_2 is valid.
REQ-014 The block SHALL have port char_last, output, 1, head byte is the string's last byte.
REQ-015 The block SHALL have port i, output, POS_W, zero-based index of the head byte within the current string.
REQ-016 The block SHALL have port string_done, output, 1, one-cycle pulse after the last byte is consumed.
REQ-017 The block SHALL have port underflow_err, output, 1, sticky flag: consume requested while empty.

Function
REQ-018 A push SHALL occur on a clk edge with in_valid && in_ready; {in_last, in_char} is written at the tail.
REQ-019 A pop SHALL occur on a clk edge with input_char_flag && char_valid; head advances by one.
REQ-020 Occupancy count SHALL be 0..DEPTH; push+pop in the same cycle SHALL leave count unchanged and both take effect.
REQ-021 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without gaps.
REQ-022 char_valid SHALL be (count>=1); char2_valid SHALL be (count>=2) && !char_last.
REQ-023 input_char/input_char_2/char_last SHALL be driven from storage at head/head+1 (combinational read); a pushed byte SHALL be visible the cycle after its handshake.
REQ-024 The FSM SHALL have states IDLE, LOAD, FLUSH.
REQ-025 IDLE: count==0, no string open; push without in_last -> LOAD; push with in_last -> FLUSH.
REQ-026 LOAD: push with in_last -> FLUSH; otherwise remain LOAD (including count reaching 0 while waiting for host).
REQ-027 FLUSH: the last byte is in the FIFO; in_ready SHALL be 0; pop of the byte with char_last=1 -> IDLE.
REQ-028 in_ready SHALL be 1 iff state!=FLUSH and count<DEPTH; in_valid while in_ready=0 SHALL be ignored.
REQ-029 i SHALL increment by 1 on each pop and SHALL return to 0 on the pop of a char_last byte; it SHALL wrap modulo 2^POS_W.
REQ-030 string_done SHALL pulse high for exactly the cycle after a char_last pop.
REQ-031 input_char_flag with char_valid=0 SHALL not change pointers, count, or i, and SHALL set underflow_err.
REQ-032 underflow_err SHALL clear only on reset.

Reset
REQ-033 reset SHALL asynchronously force state=IDLE, pointers=0, count=0, i=0, string_done=0, underflow_err=0; hence char_valid=0, char2_valid=0, in_ready=1.
REQ-034 Assertion mid-string SHALL discard all buffered bytes; after deassertion the next push SHALL start a new string at i=0.
REQ-035 FIFO storage contents need not be reset; input_char and input_char_2 are don't-care while their valid bit is 0.

Verification
REQ-036 The bench SHALL push "ab" (0x61, 0x62 with in_last) and then pulse input_char_flag twice -> input_char=0x61, input_char_2=0x62, char2_valid=1 first; then i=1, char_last=1; string_done pulses once; state=IDLE.
REQ-037 The bench SHALL push 16 bytes with no in_last while input_char_flag=0 -> in_ready=0 at count=16; a 17th in_valid is ignored; one pop restores in_ready=1.
REQ-038 The bench SHALL push and pop in the same cycle at count=5 -> count stays 5, i increments, head and tail both advance.
REQ-039 The bench SHALL pulse input_char_flag on an empty FIFO -> underflow_err=1, i=0, count=0; it stays set until reset.
REQ-040 The bench SHALL accept in_last, then hold in_valid=1 -> in_ready=0 until the last byte is popped; the next string's first byte gets i=0.
REQ-041 The bench SHALL assert reset with count=7 in LOAD -> char_valid=0, in_ready=1, i=0 immediately; no stale byte appears afterward.

Source files
------------

// File: rtl/char_stream_feeder_if.sv
// Host byte stream in, FIFO head/lookahead out to the traversal stage.
// Latency: n/a (signal bundle); backpressure via in_ready, consume via input_char_flag.
interface char_stream_feeder_if #(
   parameter int POS_W = 20
);
   logic [7:0]       in_char;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic             input_char_flag;
   logic [7:0]       input_char;
   logic [7:0]       input_char_2;
   logic             char_valid;
   logic             char2_valid;
   logic             char_last;
   logic [POS_W-1:0] i;
   logic             string_done;
   logic             underflow_err;

   modport master (
      output in_char, in_valid, in_last, input_char_flag,
      input  in_ready, input_char, input_char_2, char_valid, char2_valid,
             char_last, i, string_done, underflow_err
   );

   modport slave (
      input  in_char, in_valid, in_last, input_char_flag,
      output in_ready, input_char, input_char_2, char_valid, char2_valid,
             char_last, i, string_done, underflow_err
   );
endinterface

// File: rtl/char_stream_feeder.sv
// String byte FIFO with head/lookahead taps and per-string position counter.
// Latency: pushed byte visible next cycle; in_ready drops when full or once a string's last byte is buffered.
module char_stream_feeder #(
   parameter int DEPTH = 16,
   parameter int POS_W = 20
) (
   input logic                 clk,
   input logic                 reset,
   char_stream_feeder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

   state_t           state, state_nxt;
   logic [8:0]       mem [DEPTH];
   logic [AW-1:0]    head, tail, head_nxt;
   logic [CW-1:0]    count;
   logic [POS_W-1:0] pos;
   logic             done_q, underflow_q;
   logic             push, pop, head_last, empty_req;

   assign head_nxt  = head + AW'(1);
   assign head_last = bus.char_valid & mem[head][8];

   assign bus.char_valid    = (count != '0);
   assign bus.char2_valid   = (count >= CW'(2)) & ~head_last;
   assign bus.char_last     = head_last;
   assign bus.input_char    = mem[head][7:0];
   assign bus.input_char_2  = mem[head_nxt][7:0];
   assign bus.in_ready      = (state != FLUSH) && (count < CW'(DEPTH));
   assign bus.i             = pos;
   assign bus.string_done   = done_q;
   assign bus.underflow_err = underflow_q;

   assign push      = bus.in_valid & bus.in_ready;
   assign pop       = bus.input_char_flag & bus.char_valid;
   assign empty_req = bus.input_char_flag & ~bus.char_valid;

   // Storage is deliberately unreset; valid bits qualify every read.
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= {bus.in_last, bus.in_char};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         pos         <= '0;
         done_q      <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (push) tail <= tail + AW'(1);
         if (pop)  head <= head_nxt;
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (pop) pos <= head_last ? '0 : pos + POS_W'(1);
         done_q <= pop & head_last;
         if (empty_req) underflow_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (push) state_nxt = bus.in_last ? FLUSH : LOAD;
         end
         LOAD: begin
            if (push && bus.in_last) state_nxt = FLUSH;
         end
         FLUSH: begin
            if (pop && head_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_char_stream_feeder.sv
// Directed bench: stimulus enqueues expected bytes, a negedge monitor checks every consumed byte.
// Also checks flow-control, underflow and reset behaviour at fixed points.
module tb_char_stream_feeder;
   localparam int POS_W = 20;

   typedef struct packed {
      logic [7:0]       ch;
      logic             lst;
      logic [POS_W-1:0] pos;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   exp_pos = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic exp_done = 1'b0;

   char_stream_feeder_if #(.POS_W(POS_W)) bus ();

   char_stream_feeder #(.DEPTH(16), .POS_W(POS_W)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void expect_byte(input logic [7:0] c, input logic last);
      exp_t e;
      e.ch  = c;
      e.lst = last;
      e.pos = POS_W'(exp_pos);
      sb.push_back(e);
      exp_pos = last ? 0 : exp_pos + 1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] c, input logic last);
      bit done;
      done = 1'b0;
      bus.in_char  = c;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            expect_byte(c, last);
            done = 1'b1;
         end
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      check("push_accepted", 32'(done), 32'd1);
   endtask

   task automatic pop_one;
      bus.input_char_flag = 1'b1;
      tick();
      bus.input_char_flag = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_done = 1'b0;
      end else begin
         check("string_done", 32'(bus.string_done), 32'(exp_done));
         exp_done = 1'b0;
         if (bus.input_char_flag && bus.char_valid) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pop: got char 0x%0h, none expected", bus.input_char);
            end else begin
               mon_e = sb.pop_front();
               check("pop_char", 32'(bus.input_char), 32'(mon_e.ch));
               check("pop_i", 32'(bus.i), 32'(mon_e.pos));
               check("pop_last", 32'(bus.char_last), 32'(mon_e.lst));
               exp_done = mon_e.lst;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      bus.in_char = 8'h00;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      bus.input_char_flag = 1'b0;
      #12;
      check("rst_char_valid", 32'(bus.char_valid), 32'd0);
      check("rst_char2_valid", 32'(bus.char2_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_i", 32'(bus.i), 32'd0);
      check("rst_done", 32'(bus.string_done), 32'd0);
      check("rst_underflow", 32'(bus.underflow_err), 32'd0);
      rst = 1'b0;
      tick();

      // Two-byte string "ab"
      push_byte(8'h61, 1'b0);
      push_byte(8'h62, 1'b1);
      check("ab_head", 32'(bus.input_char), 32'h61);
      check("ab_look", 32'(bus.input_char_2), 32'h62);
      check("ab_char2_valid", 32'(bus.char2_valid), 32'd1);
      check("ab_flush_ready", 32'(bus.in_ready), 32'd0);
      pop_one();
      check("ab_i", 32'(bus.i), 32'd1);
      check("ab_last", 32'(bus.char_last), 32'd1);
      check("ab_char2_off", 32'(bus.char2_valid), 32'd0);
      pop_one();
      check("ab_done_pulse", 32'(bus.string_done), 32'd1);
      check("ab_empty", 32'(bus.char_valid), 32'd0);
      check("ab_idle_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("ab_done_clear", 32'(bus.string_done), 32'd0);

      // Fill to DEPTH, overflow attempt ignored
      for (int k = 0; k < 16; k++) push_byte(8'(8'h10 + k), 1'b0);
      check("full_ready", 32'(bus.in_ready), 32'd0);
      bus.in_char  = 8'hEE;
      bus.in_valid = 1'b1;
      repeat (2) tick();
      bus.in_valid = 1'b0;
      check("full_hold", 32'(bus.in_ready), 32'd0);
      pop_one();
      check("full_pop_ready", 32'(bus.in_ready), 32'd1);
      repeat (10) pop_one();
      check("pre_simul_i", 32'(bus.i), 32'd11);

      // Simultaneous push and pop at count 5
      bus.in_char = 8'h30;
      bus.in_last = 1'b0;
      bus.in_valid = 1'b1;
      bus.input_char_flag = 1'b1;
      expect_byte(8'h30, 1'b0);
      @(negedge clk);
      check("simul_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.input_char_flag = 1'b0;
      check("simul_i", 32'(bus.i), 32'd12);
      check("simul_head", 32'(bus.input_char), 32'h1C);
      check("simul_char2", 32'(bus.char2_valid), 32'd1);
      push_byte(8'h31, 1'b1);
      n = 0;
      while (bus.char_valid && n < 20) begin
         pop_one();
         n++;
      end
      check("drain_count", 32'(n), 32'd6);
      tick();
      check("drain_ready", 32'(bus.in_ready), 32'd1);

      // Consume request on empty FIFO
      bus.input_char_flag = 1'b1;
      tick();
      bus.input_char_flag = 1'b0;
      check("uf_flag", 32'(bus.underflow_err), 32'd1);
      check("uf_i", 32'(bus.i), 32'd0);
      check("uf_empty", 32'(bus.char_valid), 32'd0);

      // in_valid held across FLUSH
      push_byte(8'h78, 1'b1);
      bus.in_char = 8'h79;
      bus.in_last = 1'b1;
      bus.in_valid = 1'b1;
      repeat (3) begin
         tick();
         check("flush_block", 32'(bus.in_ready), 32'd0);
      end
      bus.input_char_flag = 1'b1;
      tick();
      bus.input_char_flag = 1'b0;
      expect_byte(8'h79, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      check("next_valid", 32'(bus.char_valid), 32'd1);
      check("next_i", 32'(bus.i), 32'd0);
      check("next_head", 32'(bus.input_char), 32'h79);
      check("uf_sticky", 32'(bus.underflow_err), 32'd1);
      pop_one();
      tick();

      // Reset mid-string with 7 bytes buffered
      for (int k = 0; k < 7; k++) push_byte(8'(8'h40 + k), 1'b0);
      check("pre_rst_valid", 32'(bus.char_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus.char_valid), 32'd0);
      check("mid_rst_char2", 32'(bus.char2_valid), 32'd0);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      check("mid_rst_i", 32'(bus.i), 32'd0);
      check("mid_rst_uf", 32'(bus.underflow_err), 32'd0);
      sb.delete();
      exp_pos = 0;
      @(posedge clk);
      #3 rst = 1'b0;
      tick();
      check("no_stale", 32'(bus.char_valid), 32'd0);
      push_byte(8'h7A, 1'b1);
      check("post_rst_i", 32'(bus.i), 32'd0);
      check("post_rst_head", 32'(bus.input_char), 32'h7A);
      pop_one();
      tick();
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
